// File: rtl/colour_pkg.sv
// Shared colour-path definitions: channel/pixel widths, distance width and
// the default palette (8-colour RGB cube, repeating every 8 entries).
package colour_pkg;

    localparam int RGB_W  = 24;
    localparam int CH_W   = 8;
    localparam int DIST_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } pq_state_t;

    function automatic logic [RGB_W-1:0] default_colour(input int unsigned k);
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
        r = k[2] ? 8'hFF : 8'h00;
        g = k[1] ? 8'hFF : 8'h00;
        b = k[0] ? 8'hFF : 8'h00;
        return {r, g, b};
    endfunction

endpackage

// File: rtl/rgb_sq_dist.sv
// Combinational squared Euclidean distance between two packed RGB pixels.
module rgb_sq_dist
    import colour_pkg::*;
(
    input  logic [RGB_W-1:0]  a_i,
    input  logic [RGB_W-1:0]  b_i,
    output logic [DIST_W-1:0] dist_o
);

    logic [2*CH_W-1:0] sq [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [CH_W-1:0] ca;
        logic [CH_W-1:0] cb;
        logic [CH_W-1:0] diff;
        assign ca   = a_i[gi*CH_W +: CH_W];
        assign cb   = b_i[gi*CH_W +: CH_W];
        assign diff = (ca >= cb) ? (ca - cb) : (cb - ca);
        assign sq[gi] = diff * diff;
    end

    // Three 16-bit squares sum to at most 195075, which fits in 18 bits.
    assign dist_o = DIST_W'(sq[0]) + DIST_W'(sq[1]) + DIST_W'(sq[2]);

endmodule

// File: rtl/palette_quantizer.sv
// Nearest-palette-entry search: one entry per cycle, strict-less compare so
// the lowest index wins ties; result held under backpressure.
module palette_quantizer
    import colour_pkg::*;
#(
    parameter int PALETTE_SIZE = 8,
    parameter int IDX_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RGB_W-1:0] in_rgb,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_addr,
    input  logic [RGB_W-1:0] pal_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [RGB_W-1:0] out_rgb
);

    pq_state_t         state_q;
    logic [RGB_W-1:0]  pix_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [DIST_W-1:0] best_dist_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [RGB_W-1:0]  best_rgb_q;
    logic              out_valid_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [RGB_W-1:0]  out_rgb_q;

    logic [RGB_W-1:0]  pal_q [PALETTE_SIZE];
    logic [RGB_W-1:0]  cur_rgb;
    logic [DIST_W-1:0] cur_dist;
    logic              pal_wr_en;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_rgb   = out_rgb_q;

    assign pal_wr_en = pal_we && (state_q == ST_IDLE) && (int'(pal_addr) < PALETTE_SIZE);

    for (genvar gi = 0; gi < PALETTE_SIZE; gi++) begin : g_pal
        always_ff @(posedge clk) begin
            if (!reset) begin
                pal_q[gi] <= default_colour(gi);
            end else if (pal_wr_en && (pal_addr == IDX_W'(gi))) begin
                pal_q[gi] <= pal_data;
            end
        end
    end

    assign cur_rgb = pal_q[cnt_q];

    rgb_sq_dist u_dist (
        .a_i    (pix_q),
        .b_i    (cur_rgb),
        .dist_o (cur_dist)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pix_q       <= '0;
            cnt_q       <= '0;
            best_dist_q <= '1;
            best_idx_q  <= '0;
            best_rgb_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_rgb_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        pix_q       <= in_rgb;
                        cnt_q       <= '0;
                        best_dist_q <= '1;
                        state_q     <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (cur_dist < best_dist_q) begin
                        best_dist_q <= cur_dist;
                        best_idx_q  <= cnt_q;
                        best_rgb_q  <= cur_rgb;
                    end
                    if (cnt_q == IDX_W'(PALETTE_SIZE - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes the final best into the output registers.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= best_idx_q;
                        out_rgb_q   <= best_rgb_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_palette_quantizer.sv
// Directed bench for palette_quantizer with hand-computed expected results.
module tb_palette_quantizer;

    localparam int PALETTE_SIZE = 8;
    localparam int IDX_W        = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [23:0]       in_rgb = '0;
    logic              pal_we = 1'b0;
    logic [IDX_W-1:0]  pal_addr = '0;
    logic [23:0]       pal_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_idx;
    logic [23:0]       out_rgb;

    int tests_run = 0;
    int tests_failed = 0;

    palette_quantizer #(
        .PALETTE_SIZE (PALETTE_SIZE),
        .IDX_W        (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_rgb   (out_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic pal_write(input logic [IDX_W-1:0] addr, input logic [23:0] data);
        pal_we   = 1'b1;
        pal_addr = addr;
        pal_data = data;
        @(posedge clk); #1;
        pal_we   = 1'b0;
    endtask

    // Present a pixel, count edges after acceptance until out_valid; optionally
    // pulse a palette write wr_at edges after acceptance.
    task automatic run_pixel(input logic [23:0] rgb, input int wr_at,
                             input logic [IDX_W-1:0] wr_addr, input logic [23:0] wr_data,
                             output int lat);
        in_rgb   = rgb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (lat == wr_at) begin
                pal_we   = 1'b1;
                pal_addr = wr_addr;
                pal_data = wr_data;
            end else begin
                pal_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        pal_we = 1'b0;
    endtask

    task automatic ack;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_rgb",   32'(out_rgb),   32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // F01020 -> red (dist 1505), latency 9 edges
        run_pixel(24'hF01020, -1, '0, '0, lat);
        check("red_latency", 32'(lat),     32'd9);
        check("red_idx",     32'(out_idx), 32'd4);
        check("red_rgb",     32'(out_rgb), 32'hFF0000);
        ack();
        check("red_ack_in_ready", 32'(in_ready), 32'd1);

        // 808080 -> white 48387 beats black 49152
        run_pixel(24'h808080, -1, '0, '0, lat);
        check("grey_idx", 32'(out_idx), 32'd7);
        check("grey_rgb", 32'(out_rgb), 32'hFFFFFF);
        ack();

        // Tie at distance 256: lower index wins
        pal_write(3'd2, 24'h100000);
        pal_write(3'd6, 24'h300000);
        run_pixel(24'h200000, -1, '0, '0, lat);
        check("tie_idx", 32'(out_idx), 32'd2);
        check("tie_rgb", 32'(out_rgb), 32'h100000);

        // Backpressure: hold result for 5 cycles
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", c),    32'(out_valid), 32'd1);
            check($sformatf("bp%0d_idx", c),      32'(out_idx),   32'd2);
            check($sformatf("bp%0d_rgb", c),      32'(out_rgb),   32'h100000);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready),  32'd0);
        end
        ack();
        check("bp_release_valid",    32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready),  32'd1);

        // Write to entry 4 during SEARCH must be ignored
        run_pixel(24'hF01020, 3, 3'd4, 24'h000000, lat);
        check("wsearch_idx", 32'(out_idx), 32'd4);
        check("wsearch_rgb", 32'(out_rgb), 32'hFF0000);
        ack();
        run_pixel(24'hF01020, -1, '0, '0, lat);
        check("wsearch_next_idx", 32'(out_idx), 32'd4);
        check("wsearch_next_rgb", 32'(out_rgb), 32'hFF0000);
        ack();

        // Reset mid-search restores defaults and discards the result
        pal_write(3'd0, 24'hABCDEF);
        in_rgb   = 24'h000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        run_pixel(24'h000000, -1, '0, '0, lat);
        check("midrst_latency", 32'(lat),     32'd9);
        check("midrst_idx",     32'(out_idx), 32'd0);
        check("midrst_rgb",     32'(out_rgb), 32'h000000);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
